// File: rtl/signed_frac_scale_seq.sv
// ============================================================================
// Module   : signed_frac_scale_seq
// Function : Sequential shift-add scaling of a signed sample by a sign-magnitude
//            fraction, y = (sgn ? -1 : +1) * x * c / 2^COEF_BITS, one bit per clock.
//            Optional macro SIGNED_FRAC_SCALE_ROUND_EN selects round-half-up
//            instead of floor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module signed_frac_scale_seq #(
    parameter int WIDTH     = 10,
    parameter int COEF_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [COEF_BITS-1:0] c,
    input  logic                 sgn,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     y,
    output logic                 busy
);

    localparam int ACC_W = WIDTH + COEF_BITS + 1;
    localparam int CNT_W = (COEF_BITS > 1) ? $clog2(COEF_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(COEF_BITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

`ifdef SIGNED_FRAC_SCALE_ROUND_EN
    // After COEF_BITS exact right shifts this preset becomes 2^(COEF_BITS-1).
    localparam logic signed [ACC_W-1:0] ACC_INIT = ACC_W'(1) << (2 * COEF_BITS - 1);
`else
    localparam logic signed [ACC_W-1:0] ACC_INIT = '0;
`endif

    logic [1:0]              state;
    logic [1:0]              state_next;
    logic [WIDTH-1:0]        x_q;
    logic [COEF_BITS-1:0]    c_q;
    logic                    sgn_q;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        step;
    logic [WIDTH-1:0]        y_q;

    logic                    accept;
    logic                    last_step;
    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [WIDTH-1:0] q;
    logic [WIDTH-1:0]        y_calc;

    assign accept    = in_valid && (state == S_IDLE) && !abort;
    assign last_step = (step == LAST_STEP);

    // Datapath: the pre-shifted sample keeps every partial sum exact in ACC_W bits.
    assign addend   = c_q[step] ? $signed({x_q[WIDTH-1], x_q, {COEF_BITS{1'b0}}})
                                : '0;
    assign sum      = acc + addend;
    assign acc_next = sum >>> 1;
    assign q        = WIDTH'(acc_next >>> COEF_BITS);
    assign y_calc   = sgn_q ? WIDTH'(-q) : WIDTH'(q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_RUN;
            S_RUN:   if (last_step) state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort) begin
            state_next = S_IDLE;
        end
    end

    // Output decode
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        busy      = (state == S_RUN) || (state == S_DONE);
    end

    // Operand capture, accumulator, step counter and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            c_q   <= '0;
            sgn_q <= 1'b0;
            acc   <= '0;
            step  <= '0;
            y_q   <= '0;
        end else begin
            if (accept) begin
                x_q   <= x;
                c_q   <= c;
                sgn_q <= sgn;
                acc   <= ACC_INIT;
                step  <= '0;
            end else if (state == S_RUN) begin
                acc  <= acc_next;
                step <= step + 1'b1;
                if (last_step && !abort) begin
                    y_q <= y_calc;
                end
            end
        end
    end

    assign y = y_q;

endmodule

`default_nettype wire

// File: tb/tb_signed_frac_scale_seq.sv
// ============================================================================
// Module   : tb_signed_frac_scale_seq
// Function : Directed and randomised self-checking bench for signed_frac_scale_seq
//            (WIDTH=10, COEF_BITS=4); honours SIGNED_FRAC_SCALE_ROUND_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_signed_frac_scale_seq;

    localparam int WIDTH     = 10;
    localparam int COEF_BITS = 4;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] x;
    logic [COEF_BITS-1:0]    c;
    logic                    sgn;
    logic                    abort;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] y;
    logic                    busy;

    int n_cmp;
    int n_err;

    signed_frac_scale_seq #(
        .WIDTH    (WIDTH),
        .COEF_BITS(COEF_BITS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .c        (c),
        .sgn      (sgn),
        .abort    (abort),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [WIDTH-1:0] model_y(input int xv, input int cv, input bit s);
        int p;
        int qv;
        p = xv * cv;
`ifdef SIGNED_FRAC_SCALE_ROUND_EN
        p = p + 8;
`endif
        qv = p >>> 4;
        if (s) qv = -qv;
        return qv[WIDTH-1:0];
    endfunction

    // Issues one operand (called #1 after a rising edge), waits for the result,
    // stalls the consumer for 'stall' cycles, then retires it.
    task automatic run_op(input logic signed [WIDTH-1:0] xi, input logic [COEF_BITS-1:0] ci,
                          input logic si, input int stall,
                          output logic signed [WIDTH-1:0] yo, output int lat,
                          output bit hs_bad, output bit stall_bad);
        logic signed [WIDTH-1:0] y0;
        hs_bad    = 1'b0;
        stall_bad = 1'b0;
        x = xi; c = ci; sgn = si; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = WIDTH'($urandom); c = COEF_BITS'($urandom); sgn = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (in_ready || !busy) hs_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        yo = y;
        y0 = y;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (!out_valid || y !== y0 || in_ready || !busy) stall_bad = 1'b1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        x = '0; c = '0; sgn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (y !== 10'sd0) begin n_err++; $display("FAIL reset_y got=%0d exp=0", y); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic signed [WIDTH-1:0] yo;
        int lat;
        bit hb, sb;
        run_op(10'sd100, 4'd8, 1'b0, 0, yo, lat, hb, sb);
        n_cmp++; if (yo !== 10'sd50) begin n_err++; $display("FAIL basic_y got=%0d exp=50", yo); end
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        n_cmp++; if (hb) begin n_err++; $display("FAIL basic_in_ready_busy got=bad exp=in_ready0_busy1"); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_idle_after got=%b exp=1", in_ready); end
    endtask

    task automatic test_arith;
        logic signed [WIDTH-1:0] yo;
        logic signed [WIDTH-1:0] ex;
        int lat;
        bit hb, sb;
`ifdef SIGNED_FRAC_SCALE_ROUND_EN
        ex = -10'sd3;
`else
        ex = -10'sd4;
`endif
        run_op(-10'sd7, 4'd8, 1'b0, 0, yo, lat, hb, sb);
        n_cmp++; if (yo !== ex) begin n_err++; $display("FAIL neg_small_y got=%0d exp=%0d", yo, ex); end
        run_op(-10'sd512, 4'd15, 1'b1, 0, yo, lat, hb, sb);
        n_cmp++; if (yo !== 10'sd480) begin n_err++; $display("FAIL min_x_neg_y got=%0d exp=480", yo); end
        run_op(10'sd511, 4'd15, 1'b0, 0, yo, lat, hb, sb);
        n_cmp++; if (yo !== 10'sd479) begin n_err++; $display("FAIL max_x_y got=%0d exp=479", yo); end
        run_op(-10'sd300, 4'd0, 1'b1, 0, yo, lat, hb, sb);
        n_cmp++; if (yo !== 10'sd0) begin n_err++; $display("FAIL c0_y got=%0d exp=0", yo); end
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL c0_latency got=%0d exp=4", lat); end
        run_op(-10'sd100, 4'd3, 1'b1, 0, yo, lat, hb, sb);
        n_cmp++; if (yo !== 10'sd19) begin n_err++; $display("FAIL neg_sgn_y got=%0d exp=19", yo); end
`ifdef SIGNED_FRAC_SCALE_ROUND_EN
        ex = 10'sd12;
`else
        ex = 10'sd11;
`endif
        run_op(10'sd37, 4'd5, 1'b0, 0, yo, lat, hb, sb);
        n_cmp++; if (yo !== ex) begin n_err++; $display("FAIL pos_frac_y got=%0d exp=%0d", yo, ex); end
    endtask

    task automatic test_back_to_back;
        logic signed [WIDTH-1:0] yo;
        int lat;
        bit hb, sb;
        run_op(10'sd511, 4'd15, 1'b0, 10, yo, lat, hb, sb);
        n_cmp++; if (yo !== 10'sd479) begin n_err++; $display("FAIL stall_y got=%0d exp=479", yo); end
        n_cmp++; if (sb) begin n_err++; $display("FAIL stall_hold got=unstable exp=stable"); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_idle got=%b exp=1", in_ready); end
        run_op(10'sd100, 4'd8, 1'b1, 0, yo, lat, hb, sb);
        n_cmp++; if (yo !== -10'sd50) begin n_err++; $display("FAIL b2b_y got=%0d exp=-50", yo); end
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_abort;
        bit seen;
        x = 10'sd100; c = 4'd8; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen) begin n_err++; $display("FAIL abort_out_valid got=1 exp=0"); end
        x = 10'sd5; c = 4'd4; in_valid = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; abort = 1'b0;
        n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL abort_idle_accept got=busy%b_ready%b exp=busy0_ready1", busy, in_ready);
        end
    endtask

    task automatic test_async_reset;
        x = 10'sd200; c = 4'd9; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || y !== 10'sd0) begin
            n_err++; $display("FAIL async_reset got=rdy%b_ov%b_busy%b_y%0d exp=rdy1_ov0_busy0_y0",
                              in_ready, out_valid, busy, y);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic signed [WIDTH-1:0] xs;
        logic [COEF_BITS-1:0]    cs;
        logic                    ss;
        logic signed [WIDTH-1:0] yo;
        logic signed [WIDTH-1:0] ex;
        int lat;
        bit hb, sb;
        for (int n = 0; n < 300; n++) begin
            xs = WIDTH'($urandom);
            cs = COEF_BITS'($urandom);
            ss = 1'($urandom);
            ex = model_y(int'(xs), int'(cs), ss);
            run_op(xs, cs, ss, int'($urandom_range(0, 3)), yo, lat, hb, sb);
            n_cmp++;
            if (yo !== ex || lat != 4 || hb || sb) begin
                n_err++;
                $display("FAIL random_op x=%0d c=%0d s=%0d got=%0d lat=%0d exp=%0d lat=4",
                         xs, cs, ss, yo, lat, ex);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_arith();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
